// File: rtl/weight_serializer.sv
// weight_serializer: shifts a parallel word out one bit per FIFO write.
// Define SER_MSB_FIRST_EN to emit bit P-1 first instead of bit 0.
module weight_serializer #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        precision,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    input  logic              fifo_full,
    output logic              wr_en,
    output logic              dout,
    output logic              busy,
    output logic              word_done
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam logic [4:0] DW    = 5'(DATA_W);

    logic [0:0]        state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [4:0]        prec_q, prec_d;
    logic              done_q, done_d;
    logic [4:0]        p_raw, p_eff;
    logic              last, head, hs;

    // precision 0 means 16; never emit more bits than the word holds
    assign p_raw = (precision == 4'd0) ? 5'd16 : {1'b0, precision};
    assign p_eff = (p_raw > DW) ? DW : p_raw;

`ifdef SER_MSB_FIRST_EN
    logic [15:0] sreg_ext;
    assign sreg_ext = 16'(sreg_q);
    assign head     = sreg_ext[4'(prec_q - 5'd1)];
`else
    assign head = sreg_q[0];
`endif

    assign busy      = (state_q == SHIFT);
    assign last      = (cnt_q == prec_q - 5'd1);
    assign wr_en     = busy & ~fifo_full;
    assign dout      = busy & head;
    assign in_ready  = ~busy | (last & wr_en);
    assign hs        = in_valid & in_ready;
    assign word_done = done_q;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        prec_d  = prec_q;
        done_d  = wr_en & last;
        if (hs) begin
            state_d = SHIFT;
            sreg_d  = in_data;
            cnt_d   = 5'd0;
            prec_d  = p_eff;
        end else if (wr_en) begin
`ifdef SER_MSB_FIRST_EN
            sreg_d = {sreg_q[DATA_W-2:0], 1'b0};
`else
            sreg_d = {1'b0, sreg_q[DATA_W-1:1]};
`endif
            cnt_d = cnt_q + 5'd1;
            if (last) begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= 5'd0;
            prec_q  <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            prec_q  <= prec_d;
            done_q  <= done_d;
        end
    end

endmodule
